// File: rtl/color_changer_pkg.sv
// Shared constants and the keypad position-to-hex map for the colour entry block.
package color_changer_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int COLOR_W    = 24;
  localparam int NIBBLE_W   = 4;
  localparam int COUNT_W    = 3;

  // Row-major map indexed by {row, col}.
  function automatic logic [NIBBLE_W-1:0] key_to_nibble(input logic [3:0] key);
    logic [NIBBLE_W-1:0] nibble;
    // NOTE: the default arm gives every input a value, so no latch is inferred.
    case (key)
      4'd0:    nibble = 4'h1;
      4'd1:    nibble = 4'h2;
      4'd2:    nibble = 4'h3;
      4'd3:    nibble = 4'hA;
      4'd4:    nibble = 4'h4;
      4'd5:    nibble = 4'h5;
      4'd6:    nibble = 4'h6;
      4'd7:    nibble = 4'hB;
      4'd8:    nibble = 4'h7;
      4'd9:    nibble = 4'h8;
      4'd10:   nibble = 4'h9;
      4'd11:   nibble = 4'hC;
      4'd12:   nibble = 4'h0;
      4'd13:   nibble = 4'hF;
      4'd14:   nibble = 4'hE;
      default: nibble = 4'hD;
    endcase
    return nibble;
  endfunction

endpackage

// File: rtl/color_changer_keypad_decoder.sv
// Combinational 4x4 keypad decoder: {row, col} to a hex digit.
module keypad_decoder
  import color_changer_pkg::*;
(
  input  logic [1:0]          row,
  input  logic [1:0]          col,
  output logic [NIBBLE_W-1:0] nibble
);

  assign nibble = key_to_nibble({row, col});

endmodule

// File: rtl/color_changer.sv
// Shifts six keypad digits, MS nibble first, into a 24-bit RGB colour; done when full.
module color_changer
  import color_changer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               button_pressed,
  input  logic [1:0]         row,
  input  logic [1:0]         col,
  output logic [COLOR_W-1:0] final_color,
  output logic               done
);

  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(NUM_DIGITS);
  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(NUM_DIGITS - 1);

  logic [COUNT_W-1:0]  count;
  logic [NIBBLE_W-1:0] nibble;

  keypad_decoder u_decoder (
    .row    (row),
    .col    (col),
    .nibble (nibble)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      final_color <= '0;
      done        <= 1'b0;
    end else if (button_pressed && count < FULL_COUNT) begin
      // Constant-indexed slots keep the write mux simple for synthesis.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (count == COUNT_W'(i)) begin
          final_color[COLOR_W-1-NIBBLE_W*i -: NIBBLE_W] <= nibble;
        end
      end
      count <= count + 1'b1;
      if (count == LAST_COUNT) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_color_changer.sv
// Scoreboarded bench: directed plan, exhaustive key map and random traffic against a digit-list model.
module tb_color_changer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        button_pressed = 1'b0;
  logic [1:0]  row = '0;
  logic [1:0]  col = '0;
  logic [23:0] final_color;
  logic        done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [23:0] color;
    logic        done;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   digits[$];
  int   key_map[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

  color_changer dut (
    .clk            (clk),
    .reset          (reset),
    .button_pressed (button_pressed),
    .row            (row),
    .col            (col),
    .final_color    (final_color),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] model_color();
    logic [23:0] c = '0;
    foreach (digits[i]) c |= 24'(digits[i]) << (20 - 4 * i);
    return c;
  endfunction

  // One cycle of stimulus; the model predicts the outputs after the next edge.
  task automatic drive(input logic rst, input logic press, input int r, input int c,
                       input string tag);
    exp_t e;
    @(negedge clk);
    reset          = rst;
    button_pressed = press;
    row            = 2'(r);
    col            = 2'(c);
    if (rst) digits.delete();
    else if (press && digits.size() < 6) digits.push_back(key_map[r * 4 + c]);
    e.color = model_color();
    e.done  = (digits.size() == 6);
    e.tag   = tag;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("%s_color", e.tag), 32'(final_color), 32'(e.color));
        check($sformatf("%s_done", e.tag), 32'(done), 32'(e.done));
      end
    end
  end

  initial begin : stimulus
    repeat (3) drive(1, 0, 0, 0, "reset");
    drive(0, 1, 2, 3, "press_c");
    drive(0, 0, 3, 1, "idle");
    drive(0, 1, 1, 1, "press_5");
    drive(0, 1, 0, 3, "press_a");
    drive(0, 1, 3, 0, "press_0");
    drive(0, 1, 3, 3, "press_d");
    drive(0, 1, 2, 1, "press_8");
    drive(0, 1, 0, 0, "ignored");
    drive(0, 0, 0, 0, "hold");
    @(negedge clk);
    check("plan_literal_color", 32'(final_color), 32'h00c5a0d8);
    check("plan_literal_done", 32'(done), 32'd1);

    for (int k = 0; k < 16; k++) begin
      drive(1, 0, 0, 0, "map_reset");
      drive(0, 1, k / 4, k % 4, $sformatf("map_key%0d", k));
    end

    drive(1, 0, 0, 0, "mid_reset");
    drive(0, 1, 0, 1, "mid_d0");
    drive(0, 1, 1, 2, "mid_d1");
    drive(0, 1, 2, 2, "mid_d2");
    drive(1, 1, 3, 2, "mid_rst_press");
    drive(0, 1, 1, 3, "mid_first");

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6,
            $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end

    drive(0, 0, 0, 0, "tail");
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
